demux4_reg: RTL
===============

Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the mux4_1 selector.
- Steers a single input sample stream onto one of four output lanes, either by explicit select {s0,s1} or by an internal round-robin lane pointer (TDM de-interleave).
- Each lane has a one-entry holding register with a valid/ready handshake.
- Sits between a shared serial sample source and four per-channel consumers.

Parameters:
- WIDTH, 1, data width of din and y0..y3.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- auto_en  input  1  1 = round-robin lane selection; 0 = select from {s0,s1}.
- s0  input  1  lane select MSB (lane = {s0,s1}).
- s1  input  1  lane select LSB.
- din  input  WIDTH  input sample.
- din_valid  input  1  din holds a sample.
- din_ready  output  1  block can accept din this cycle (combinational).
- y0, y1, y2, y3  output  WIDTH each  lane holding registers.
- y_valid  output  4  bit N = lane N register holds an unconsumed sample.
- y_ready  input  4  bit N = consumer N takes yN this cycle.
- cur_ch  output  2  lane targeted this cycle.
- frame_done  output  1  one-cycle pulse: round-robin frame of 4 samples completed.

Behaviour:
- Reset (async, rst=1): y0..y3=0, y_valid=4'b0000, rr_ptr=0, frame_done=0, auto_en history register=0. Outputs stay at these values while rst=1.
- Target lane T:
  - T = rr_ptr when auto_en=1; T = {s0,s1} when auto_en=0.
  - cur_ch = T (combinational).
- din_ready = !y_valid[T] | y_ready[T]. Pass-through of ready is allowed; there is no combinational path from din_valid to din_ready.
- Accept = din_valid & din_ready. On accept:
  - yT <= din and y_valid[T] <= 1 at the next edge.
  - Latency is 1 cycle from accept to valid output.
- Drain: if y_valid[N] & y_ready[N] and lane N is not written in the same cycle, y_valid[N] <= 0 and yN holds its last value.
  - If lane N is drained and written in the same cycle: yN <= din, y_valid[N] stays 1. No bubble, no loss.
- y_ready[N] while y_valid[N]=0 is ignored.
- Non-target lanes drain independently, all four in parallel.
- Round-robin pointer rr_ptr (2-bit state CH0->CH1->CH2->CH3->CH0):
  - Advances only on accept while auto_en=1; wraps 3->0.
  - Holds when auto_en=0.
  - Holds on a stall: din_valid=1 with din_ready=0 does not advance and drops nothing.
  - auto_en rising edge (0 in previous cycle, 1 now): rr_ptr is forced to 0 for this cycle's targeting, so the first sample goes to lane 0. An accept in that cycle then sets rr_ptr to 1.
- frame_done: registered; equals 1 in the cycle after an accept to lane 3 while auto_en=1; otherwise 0. Never asserts in select mode.
- s0/s1 changes while auto_en=0 take effect combinationally the same cycle. An accept uses the select value present at the clock edge.
- Reset mid-operation: all pending y_valid are cleared immediately; pending samples are lost; rr_ptr returns to 0.
- No sample is ever dropped or duplicated; the input stalls instead.

Test Plan:
- Reset then select mode: rst pulse; auto_en=0, {s0,s1}=2'b10, din=1, din_valid=1 for 1 cycle, y_ready=0 -> next cycle y2=1, y_valid=4'b0100; other lanes 0; din_ready=0 while {s0,s1} stays 2'b10.
- Sweep matching the mux bench: WIDTH=4; for j=0..3 set {s0,s1}=j, send din=j+5, all y_ready=1 -> lane j shows j+5 one cycle later with its y_valid pulsing for 1 cycle; non-target lanes unchanged.
- Round-robin frame: auto_en 0->1, send din=1,2,3,4 back-to-back, y_ready=4'b1111 -> y0..y3 = 1,2,3,4 on consecutive cycles; frame_done pulses once, in the cycle after din=4 is accepted; cur_ch sequence 0,1,2,3,0.
- Backpressure: auto_en=1, y_ready=0, send 5 samples -> 4 accepted, lanes all valid, din_ready=0 at the 5th; then y_ready[0]=1 -> 5th accepted into y0 in that cycle, rr_ptr becomes 1, no loss.
- Simultaneous drain/write: lane 1 valid holding 0xA; y_ready[1]=1 and accept of 0xB to lane 1 same cycle -> y1=0xB, y_valid[1] stays 1.
- Async reset mid-frame: after 2 round-robin accepts, assert rst between clock edges -> y_valid=0 and y0..y3=0 immediately; after release, the first accept goes to lane 0.

Source files
------------

// File: rtl/demux4_reg.sv
// demux4_reg -- registered 1-to-4 demultiplexer.
//
// Steers one input sample stream onto four output lanes, each backed by a
// one-entry holding register with a valid/ready handshake. The target lane
// comes from either the explicit select {s0,s1} or an internal round-robin
// pointer (TDM de-interleave).
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   auto_en          1 = round-robin lane selection, 0 = lane = {s0,s1}
//   s0, s1           explicit lane select (MSB, LSB)
//   din, din_valid   input sample and its qualifier
//   din_ready        target lane can take din this cycle (combinational)
//   y0..y3           lane holding registers
//   y_valid[N]       lane N holds an unconsumed sample
//   y_ready[N]       consumer N takes yN this cycle
//   cur_ch           lane targeted this cycle
//   frame_done       one-cycle pulse after the 4th sample of a round-robin frame
module demux4_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             auto_en,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic [1:0]       cur_ch,
  output logic             frame_done
);

  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic [3:0]       y_valid_q, y_valid_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             frame_done_q, frame_done_d;
  logic             auto_en_q, auto_en_d;

  logic             auto_rise;
  logic [1:0]       rr_eff;
  logic [1:0]       tgt;
  logic             accept;

  // A fresh entry into round-robin mode always starts the frame at lane 0,
  // whatever the pointer was left at.
  assign auto_rise = auto_en & ~auto_en_q;
  assign rr_eff    = auto_rise ? 2'd0 : rr_ptr_q;
  assign tgt       = auto_en ? rr_eff : {s0, s1};

  // Ready looks only at the target lane's state and its consumer; a lane
  // being drained this cycle can be refilled in the same cycle.
  assign din_ready = ~y_valid_q[tgt] | y_ready[tgt];
  assign accept    = din_valid & din_ready;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    y_d          = y_q;
    y_valid_d    = y_valid_q;
    rr_ptr_d     = rr_ptr_q;
    frame_done_d = 1'b0;
    auto_en_d    = auto_en;

    for (int n = 0; n < 4; n++) begin
      if (accept && (tgt == 2'(n))) begin
        y_d[n]       = din;
        y_valid_d[n] = 1'b1;
      end else if (y_ready[n]) begin
        // Drain leaves the data in place; ready on an empty lane is harmless.
        y_valid_d[n] = 1'b0;
      end
    end

    if (auto_en) begin
      // Store the effective pointer so a rising edge without an accept still
      // leaves the next frame starting at lane 0.
      rr_ptr_d     = accept ? rr_eff + 2'd1 : rr_eff;
      frame_done_d = accept && (tgt == 2'd3);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) y_q[n] <= '0;
      y_valid_q    <= 4'b0000;
      rr_ptr_q     <= 2'd0;
      frame_done_q <= 1'b0;
      auto_en_q    <= 1'b0;
    end else begin
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      frame_done_q <= frame_done_d;
      auto_en_q    <= auto_en_d;
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y_valid    = y_valid_q;
  assign cur_ch     = tgt;
  assign frame_done = frame_done_q;

endmodule
